subtractor_4bit: RTL and testbench
==================================

// Module: subtractor_4bit
// PURPOSE
//   Registered unsigned 4-bit subtractor: Diff = A - B (mod 2^WIDTH), Borrow = (A < B).
//   Arithmetic leaf block for datapaths needing a difference plus an underflow flag.
//   Ripple-borrow chain of full-subtractor cells, one output register stage,
//   valid-qualified result.
// PARAMETERS
//   WIDTH  4  operand/result width in bits; must be >= 1; default build is 4-bit
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      synchronous, active-low reset (sampled on clk rising edge)
//   in_valid   in   1      A/B valid this cycle; result captured when high
//   A          in   WIDTH  minuend, unsigned
//   B          in   WIDTH  subtrahend, unsigned
//   out_valid  out  1      Diff/Borrow hold a fresh result (1-cycle pulse per accepted op)
//   Diff       out  WIDTH  registered (A - B) mod 2^WIDTH
//   Borrow     out  1      registered borrow-out of MSB stage: 1 iff A < B (unsigned)
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst_n is synchronous and active-low.
//   - Reset: while rst_n==0 at a clk edge -> Diff=0, Borrow=0, out_valid=0. No async path.
//   - Combinational core: bin[0]=0;
//       d[i]    = A[i] ^ B[i] ^ bin[i]
//       bin[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bin[i])
//       Borrow  = bin[WIDTH]
//   - Latency: exactly 1 cycle. Operands sampled at edge N with in_valid=1 appear on
//     Diff/Borrow with out_valid=1 after edge N.
//   - in_valid=0 at an edge: out_valid<=0; Diff/Borrow hold their last value (no update).
//   - Back-to-back: in_valid high every cycle gives one result per cycle, no bubbles.
//   - Underflow wraps modulo 2^WIDTH with Borrow=1; e.g. 4-9 -> Diff=4'hB, Borrow=1.
//   - Equal operands -> Diff=0, Borrow=0. A=0,B=0 -> 0/0.
//   - No backpressure: downstream must consume out_valid in the cycle it is asserted.
//   - Reset has priority over in_valid in the same cycle. Reset mid-stream discards the
//     in-flight result; first valid result after reset needs a fresh in_valid.
//   - No X propagation from outputs after reset; inputs are don't-care when in_valid=0.
// STRUCTURE
//   - Shared package sub_pkg: localparam SUB_WIDTH_DEFAULT = 4; typedef logic [WIDTH-1:0] operand_t.
//   - Sub-module full_subtractor (a, b, bin -> d, bout), instantiated WIDTH times in a
//     generate loop to form the ripple-borrow chain.
//   - Top: generate chain + single always_ff output register (Diff, Borrow, out_valid).
// TESTING
//   1. Reset: rst_n=0 two cycles with in_valid=1, A=9, B=3 -> Diff=0, Borrow=0, out_valid=0.
//   2. A=9, B=3, in_valid=1 -> next cycle Diff=6, Borrow=0, out_valid=1.
//      Also: 7-5 -> Diff=2, Borrow=0; 10-2 -> Diff=8, Borrow=0.
//   3. Underflow: A=4, B=9 -> Diff=4'b1011 (11), Borrow=1. Also 0-1 -> Diff=15, Borrow=1.
//   4. Equal operands: A=15, B=15 -> Diff=0, Borrow=0. Also A=0, B=0 -> 0/0.
//   5. Streaming/hold: A/B sequence with in_valid gaps -> one result per valid cycle,
//      out_valid=0 and Diff/Borrow unchanged in gap cycles.
//   6. Reset mid-stream: rst_n=0 coincident with in_valid=1 -> outputs 0, out_valid=0
//      next cycle. Then exhaustive 256-pair sweep checked against (A-B)&15 and (A<B).

Source files
------------

// File: rtl/sub_pkg.sv
// sub_pkg
//   Shared definitions for the registered subtractor.
//   SUB_WIDTH_DEFAULT : default operand/result width (4-bit build)
//   operand_t         : operand/result type at the default width
package sub_pkg;

  localparam int SUB_WIDTH_DEFAULT = 4;

  typedef logic [SUB_WIDTH_DEFAULT-1:0] operand_t;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// full_subtractor
//   One bit cell of the ripple-borrow chain.
//   Ports:
//     a    in   minuend bit
//     b    in   subtrahend bit
//     bin  in   borrow from the next-lower bit
//     d    out  difference bit
//     bout out  borrow into the next-higher bit
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d = a ^ b ^ bin;

  // Borrow out when a=0,b=1, or when a==b and a borrow arrives from below.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/subtractor_4bit.sv
// subtractor_4bit
//   Registered unsigned subtractor: Diff = (A - B) mod 2^WIDTH, Borrow = (A < B).
//   Combinational ripple-borrow chain of full_subtractor cells feeding one
//   output register stage; results are qualified by out_valid (1-cycle latency).
//   Ports:
//     clk       in   clock, rising edge
//     rst_n     in   synchronous active-low reset
//     in_valid  in   A/B valid this cycle
//     A         in   minuend, unsigned, WIDTH bits
//     B         in   subtrahend, unsigned, WIDTH bits
//     out_valid out  fresh result on Diff/Borrow this cycle
//     Diff      out  registered difference, WIDTH bits
//     Borrow    out  registered borrow-out of the MSB stage
module subtractor_4bit
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  logic [WIDTH-1:0] diff_d;
  logic             borrow_d;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             valid_q;

  // Each stage keeps its own borrow nets so the chain is a set of distinct
  // signals rather than one vector that feeds back into itself.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    logic bin_s;
    logic bout_s;

    if (gi == 0) begin : g_lsb
      assign bin_s = 1'b0;
    end else begin : g_chain
      assign bin_s = g_stage[gi-1].bout_s;
    end

    full_subtractor u_fs (
      .a   (A[gi]),
      .b   (B[gi]),
      .bin (bin_s),
      .d   (diff_d[gi]),
      .bout(bout_s)
    );
  end : g_stage

  assign borrow_d = g_stage[WIDTH-1].bout_s;

  // Reset wins over in_valid; with in_valid low the data registers hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        diff_q   <= diff_d;
        borrow_q <= borrow_d;
      end
    end
  end

  assign Diff      = diff_q;
  assign Borrow    = borrow_q;
  assign out_valid = valid_q;

endmodule : subtractor_4bit

// File: tb/tb_subtractor_4bit.sv
// tb_subtractor_4bit
//   Directed-vector bench for subtractor_4bit with hand-computed expectations,
//   followed by a full 256-pair sweep against an arithmetic reference.
module tb_subtractor_4bit;
  import sub_pkg::*;

  logic     clk;
  logic     rst_n;
  logic     in_valid;
  operand_t a_in;
  operand_t b_in;
  logic     out_valid;
  operand_t diff;
  logic     borrow;

  int n_compared;
  int n_mismatched;

  subtractor_4bit #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (a_in),
    .B        (b_in),
    .out_valid(out_valid),
    .Diff     (diff),
    .Borrow   (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted operation with hand-computed expected result.
  task automatic do_op(input int a, input int b, input int exp_d, input int exp_b);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    a_in     = operand_t'(a);
    b_in     = operand_t'(b);
    step();
    $display("op   %0d - %0d -> diff=%0d borrow=%0d valid=%0d", a, b, diff, borrow, out_valid);
    check_eq("op_valid",  int'(out_valid), 1);
    check_eq("op_diff",   int'(diff),      exp_d);
    check_eq("op_borrow", int'(borrow),    exp_b);
  endtask

  // Idle cycle: inputs are garbage, previous result must be held.
  task automatic do_gap(input int hold_d, input int hold_b);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a_in     = 4'h1;
    b_in     = 4'hE;
    step();
    $display("gap  diff=%0d borrow=%0d valid=%0d", diff, borrow, out_valid);
    check_eq("gap_valid",  int'(out_valid), 0);
    check_eq("gap_diff",   int'(diff),      hold_d);
    check_eq("gap_borrow", int'(borrow),    hold_b);
  endtask

  task automatic do_reset_cycle(input int a, input int b);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a_in     = operand_t'(a);
    b_in     = operand_t'(b);
    step();
    $display("rst  diff=%0d borrow=%0d valid=%0d", diff, borrow, out_valid);
    check_eq("rst_valid",  int'(out_valid), 0);
    check_eq("rst_diff",   int'(diff),      0);
    check_eq("rst_borrow", int'(borrow),    0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b1;
    a_in         = 4'd9;
    b_in         = 4'd3;

    // Reset held two cycles with a live operation presented.
    do_reset_cycle(9, 3);
    do_reset_cycle(9, 3);

    // Basic differences.
    do_op(9, 3, 6, 0);
    do_op(7, 5, 2, 0);
    do_op(10, 2, 8, 0);

    // Underflow wraps.
    do_op(4, 9, 11, 1);
    do_op(0, 1, 15, 1);

    // Equal operands.
    do_op(15, 15, 0, 0);
    do_op(0, 0, 0, 0);

    // Streaming with gaps: results held, out_valid low in gaps.
    do_op(12, 5, 7, 0);
    do_gap(7, 0);
    do_op(3, 8, 11, 1);
    do_gap(11, 1);
    do_gap(11, 1);
    do_op(8, 3, 5, 0);
    do_op(1, 15, 2, 1);

    // Reset mid-stream discards the in-flight operation.
    do_reset_cycle(14, 1);
    // After release with no new in_valid, no result appears.
    do_gap(0, 0);

    // Exhaustive back-to-back sweep.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        do_op(ai, bi, (ai - bi) & 15, (ai < bi) ? 1 : 0);
      end
    end

    in_valid = 1'b0;
    step();
    check_eq("final_idle_valid", int'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_subtractor_4bit
